// File: rtl/bus_arbiter.sv
// Round-robin arbiter with registered one-hot grant and binary mux select; request-to-grant is one cycle.
// Grants hold until the owner drops its request or the hold timeout fires; each handover has a one-cycle turnaround.
module bus_arbiter #(
  parameter int NUM_REQ  = 16,
  parameter int IDX_W    = 4,
  parameter int HOLD_MAX = 64,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enb,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid,
  output logic               timeout
);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  localparam logic [CNT_W-1:0] LP_HOLD_LAST = CNT_W'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);
  localparam logic [IDX_W-1:0] LP_LAST_RST  = IDX_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] LP_ONE     = {{(NUM_REQ-1){1'b0}}, 1'b1};

  state_t             r_state, w_state_nxt;
  logic [NUM_REQ-1:0] r_gnt, w_gnt_nxt;
  logic [IDX_W-1:0]   r_idx, w_idx_nxt;
  logic               r_vld, w_vld_nxt;
  logic               r_to, w_to_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]   r_last, w_last_nxt;

  logic               w_found;
  logic [IDX_W-1:0]   w_pick;
  logic [IDX_W-1:0]   w_cand;

  // Scan starts one past the previous owner and wraps, so the last owner is considered last.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = IDX_W'((int'(r_last) + k) % NUM_REQ);
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_idx_nxt   = r_idx;
    w_vld_nxt   = r_vld;
    w_to_nxt    = 1'b0;
    w_cnt_nxt   = r_cnt;
    w_last_nxt  = r_last;
    case (r_state)
      IDLE, RELEASE: begin
        if (enb && w_found) begin
          w_state_nxt = GRANT;
          w_gnt_nxt   = LP_ONE << w_pick;
          w_idx_nxt   = w_pick;
          w_vld_nxt   = 1'b1;
          w_last_nxt  = w_pick;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = IDLE;
          w_gnt_nxt   = '0;
          w_vld_nxt   = 1'b0;
        end
      end
      GRANT: begin
        // A request drop wins over an expiring hold timer on the same edge.
        if (!req[r_idx]) begin
          w_state_nxt = RELEASE;
          w_gnt_nxt   = '0;
          w_vld_nxt   = 1'b0;
        end else if (HOLD_MAX != 0 && r_cnt == LP_HOLD_LAST) begin
          w_state_nxt = RELEASE;
          w_gnt_nxt   = '0;
          w_vld_nxt   = 1'b0;
          w_to_nxt    = 1'b1;
        end else if (HOLD_MAX != 0) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
        w_vld_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_idx   <= '0;
      r_vld   <= 1'b0;
      r_to    <= 1'b0;
      r_cnt   <= '0;
      r_last  <= LP_LAST_RST;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_idx   <= w_idx_nxt;
      r_vld   <= w_vld_nxt;
      r_to    <= w_to_nxt;
      r_cnt   <= w_cnt_nxt;
      r_last  <= w_last_nxt;
    end
  end

  assign gnt       = r_gnt;
  assign gnt_idx   = r_idx;
  assign gnt_valid = r_vld;
  assign timeout   = r_to;

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
Round-robin arbiter that shares one datapath resource (memory/bus port) among up to NUM_REQ requesters. Produces a registered one-hot grant plus a binary grant index that drives the select input of the shared multiplexer. Grants are held until the owner drops its request or a hold timeout forces release. A one-cycle turnaround separates consecutive owners.

Parameters:
NUM_REQ, 16, number of requesters (2..16)
IDX_W, 4, width of gnt_idx; ceil(log2(NUM_REQ))
HOLD_MAX, 64, maximum cycles one owner may hold the grant; 0 disables the timeout
CNT_W, 8, hold counter width; HOLD_MAX < 2^CNT_W is required

Ports:
clk  input  1  system clock; all state changes on the rising edge
rst  input  1  asynchronous, active-high reset
enb  input  1  arbitration enable; 0 blocks new grants but does not revoke the current grant
req  input  NUM_REQ  request vector; bit i set means requester i wants the resource
gnt  output  NUM_REQ  registered one-hot grant; all zero when there is no owner
gnt_idx  output  IDX_W  binary index of the owner; mux select; holds the last owner when gnt_valid=0
gnt_valid  output  1  high while a grant is active (equals the OR of gnt)
timeout  output  1  one-cycle pulse in the first RELEASE cycle of a forced release

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; gnt=0, gnt_idx=0, gnt_valid=0, timeout=0, hold_cnt=0.
  - last_idx=NUM_REQ-1, so the first search starts at requester 0.
  - Takes effect immediately, including mid-grant.
- States: IDLE, GRANT, RELEASE. All outputs are registered.
- IDLE / RELEASE arbitration:
  - If enb=1 and req!=0 at an edge, choose the first set bit scanning last_idx+1, last_idx+2, … with wrap at NUM_REQ-1 -> 0.
  - On the same edge: set gnt[w]=1, gnt_idx=w, gnt_valid=1, last_idx=w, hold_cnt=0; go to GRANT.
  - Otherwise go to or stay in IDLE.
- Latency: a request sampled at edge k in IDLE is visible as a grant immediately after edge k (one-cycle request-to-grant).
- GRANT, each edge:
  - Owner's request low (req[gnt_idx]=0): clear gnt and gnt_valid, go to RELEASE, timeout=0.
  - Else if HOLD_MAX!=0 and hold_cnt==HOLD_MAX-1: clear gnt and gnt_valid, go to RELEASE, timeout=1. The owner therefore holds for exactly HOLD_MAX cycles.
  - Else: hold_cnt += 1 and the grant stays unchanged.
  - Request drop takes priority over timeout on the same edge (no timeout pulse).
  - Changes on other req bits and on enb are ignored during GRANT.
- RELEASE:
  - Lasts exactly one cycle with gnt=0 (bus turnaround).
  - The arbitration performed at its exit edge follows the IDLE rules. The minimum gap between consecutive grants is therefore 1 cycle.
  - timeout returns to 0 after this cycle.
- Fairness:
  - The search always starts after last_idx.
  - A force-released owner that still requests is served again only after every other active requester has had a turn.
  - A sole persistent requester is re-granted after each RELEASE.
- Width rules:
  - req bits at index >= NUM_REQ do not exist.
  - gnt_idx is always < NUM_REQ.
  - hold_cnt never wraps, since it saturates by construction at HOLD_MAX-1.
- enb=0: the current owner keeps the grant until its normal release; no new grant is issued while enb=0.

Test Plan:
1. Reset then req=0x0001 -> the edge after sampling gives gnt=0x0001, gnt_idx=0, gnt_valid=1. Then drop req -> gnt=0 for one RELEASE cycle, then IDLE.
2. Round-robin: req=0x0013 held, each owner releases after 2 cycles -> owners 0,1,4,0,1,4; a 1-cycle gnt=0 gap between each; gnt_idx matches.
3. Timeout with HOLD_MAX=4: req=0x0005 held constantly -> owner 0 for exactly 4 cycles, timeout=1 in the next cycle, then owner 2 for 4 cycles, then owner 0.
4. Simultaneous events: owner's req drops on the same edge that hold_cnt==HOLD_MAX-1 -> RELEASE with timeout=0.
5. enb=0 while owner 3 is active and req=0x0108 -> owner 3 keeps the grant until its req drops, then no grant. Raising enb=1 -> owner 8 granted.
6. Async reset mid-grant: assert rst between edges while gnt=0x0100 -> gnt=0, gnt_valid=0, timeout=0 immediately. After release with req=0xFFFF -> first grant goes to index 0.
